// File: rtl/writeback_stage.sv
// MEM/WB writeback stage feeding the register-file write port.
// Two-entry skid buffer: S0 is the presented head, S1 absorbs a stalled write port.
// Load formatting (big-endian byte lanes) is done on capture, so BusW is registered.
// Optional: define WB_ALIGN_CHECK_EN to add AlignErr and suppress misaligned writes.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic              MemToReg,
    input  logic [2:0]        LoadType,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemData,
    input  logic              RegWrIn,
    input  logic [ADDR_W-1:0] RWIn,
    input  logic              WbStall,
    input  logic              Flush,
    output logic [DATA_W-1:0] BusW,
    output logic [ADDR_W-1:0] RW,
    output logic              RegWr,
`ifdef WB_ALIGN_CHECK_EN
    output logic              AlignErr,
`endif
    output logic              WbValid
);

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } loadType_e;

    logic [DATA_W-1:0] s0Data, s1Data, inData;
    logic [ADDR_W-1:0] s0Rw, s1Rw;
    logic              s0Wr, s1Wr, s0Valid, s1Valid;
    logic              s0Mis, s1Mis, inMis;
    logic              accept, retire;
    logic [7:0]        laneByte;
    logic [15:0]       halfWord;

    // Format the incoming entry: lane extraction and sign/zero extension
    always_comb begin
        laneByte = '0;
        halfWord = ALUResult[1] ? MemData[15:0] : MemData[31:16];
        case (ALUResult[1:0])
            2'd0:    laneByte = MemData[31:24];
            2'd1:    laneByte = MemData[23:16];
            2'd2:    laneByte = MemData[15:8];
            default: laneByte = MemData[7:0];
        endcase
        inData = MemData;
        inMis  = 1'b0;
        if (!MemToReg) begin
            inData = ALUResult;
        end else begin
            case (LoadType)
                LD_B:    inData = {{24{laneByte[7]}}, laneByte};
                LD_BU:   inData = {24'h0, laneByte};
                LD_H:    inData = {{16{halfWord[15]}}, halfWord};
                LD_HU:   inData = {16'h0, halfWord};
                LD_W:    inData = MemData;
                default: inData = MemData;
            endcase
`ifdef WB_ALIGN_CHECK_EN
            case (LoadType)
                LD_B, LD_BU: inMis = 1'b0;
                LD_H, LD_HU: inMis = ALUResult[0];
                default:     inMis = (ALUResult[1:0] != 2'b00);
            endcase
`endif
        end
    end

    assign accept  = InValid & InReady;
    assign retire  = s0Valid & ~WbStall;
    assign InReady = ~s1Valid;
    assign WbValid = s0Valid;
    assign BusW    = s0Data;
    assign RW      = s0Rw;
    assign RegWr   = s0Valid & s0Wr & (s0Rw != '0) & ~WbStall & ~s0Mis;
`ifdef WB_ALIGN_CHECK_EN
    assign AlignErr = retire & s0Mis;
`endif

    // Skid-buffer update: flush, then refill head from S1 or input, else hold and skid
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s0Data  <= '0;
            s0Rw    <= '0;
            s0Wr    <= 1'b0;
            s0Mis   <= 1'b0;
            s0Valid <= 1'b0;
            s1Data  <= '0;
            s1Rw    <= '0;
            s1Wr    <= 1'b0;
            s1Mis   <= 1'b0;
            s1Valid <= 1'b0;
        end else if (Flush) begin
            s0Valid <= 1'b0;
            s1Valid <= 1'b0;
        end else if (!s0Valid || retire) begin
            if (s1Valid) begin
                s0Data  <= s1Data;
                s0Rw    <= s1Rw;
                s0Wr    <= s1Wr;
                s0Mis   <= s1Mis;
                s0Valid <= 1'b1;
                s1Valid <= accept;
                if (accept) begin
                    s1Data <= inData;
                    s1Rw   <= RWIn;
                    s1Wr   <= RegWrIn;
                    s1Mis  <= inMis;
                end
            end else begin
                s0Valid <= accept;
                s1Valid <= 1'b0;
                if (accept) begin
                    s0Data <= inData;
                    s0Rw   <= RWIn;
                    s0Wr   <= RegWrIn;
                    s0Mis  <= inMis;
                end
            end
        end else if (accept) begin
            s1Data  <= inData;
            s1Rw    <= RWIn;
            s1Wr    <= RegWrIn;
            s1Mis   <= inMis;
            s1Valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: drivers push expected register writes,
// a negedge monitor pops and compares on every RegWr.
module tb_writeback_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InValid, InReady, MemToReg, RegWrIn, WbStall, Flush;
    logic [2:0]  LoadType;
    logic [31:0] ALUResult, MemData, BusW;
    logic [4:0]  RWIn, RW;
    logic        RegWr, WbValid;
`ifdef WB_ALIGN_CHECK_EN
    logic        AlignErr;
`endif

    writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .MemToReg(MemToReg), .LoadType(LoadType), .ALUResult(ALUResult),
        .MemData(MemData), .RegWrIn(RegWrIn), .RWIn(RWIn), .WbStall(WbStall),
        .Flush(Flush), .BusW(BusW), .RW(RW), .RegWr(RegWr),
`ifdef WB_ALIGN_CHECK_EN
        .AlignErr(AlignErr),
`endif
        .WbValid(WbValid)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rw;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setIn(input logic m2r, input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] mem, input logic wr, input logic [4:0] rw);
        MemToReg = m2r; LoadType = lt; ALUResult = alu; MemData = mem;
        RegWrIn = wr; RWIn = rw;
    endtask

    // Monitor: every register write must match the head of the expected queue
    always @(negedge Clk) begin
        if (Rst_n && RegWr) begin
            if (expQ.size() == 0) begin
                chk("unexpected_write_rw", {27'h0, RW}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("sb_busw", BusW, e.data);
                chk("sb_rw", {27'h0, RW}, {27'h0, e.rw});
            end
        end
    end

    // Format vectors on MemData=0x80FF7F01: {LoadType, ALUResult, expected}
    logic [2:0]  fmtLt  [8] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b000, 3'b001, 3'b001};
    logic [31:0] fmtAlu [8] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd2};
    logic [31:0] fmtExp [8] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'hFFFF_80FF,
                                32'h0000_80FF, 32'h80FF_7F01, 32'h0000_0001, 32'h0000_007F};

    initial begin
        Rst_n = 1'b0; InValid = 1'b0; WbStall = 1'b0; Flush = 1'b0;
        setIn(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
        #2;
        chk("rst_busw", BusW, 32'h0);
        chk("rst_rw", {27'h0, RW}, 32'h0);
        chk("rst_regwr", {31'h0, RegWr}, 32'h0);
        chk("rst_wbvalid", {31'h0, WbValid}, 32'h0);
        chk("rst_inready", {31'h0, InReady}, 32'h1);
        #10 Rst_n = 1'b1;
        tick();

        // Single ALU entry: presented one cycle after accept, gone the next
        setIn(1'b0, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 5'd8);
        InValid = 1'b1;
        expQ.push_back('{data: 32'h1234_5678, rw: 5'd8});
        tick();
        InValid = 1'b0;
        chk("t1_regwr", {31'h0, RegWr}, 32'h1);
        chk("t1_rw", {27'h0, RW}, 32'd8);
        chk("t1_busw", BusW, 32'h1234_5678);
        tick();
        chk("t1_regwr_after", {31'h0, RegWr}, 32'h0);
        chk("t1_wbvalid_after", {31'h0, WbValid}, 32'h0);

        // Load formatting, back-to-back at full throughput
        for (int i = 0; i < 8; i++) begin
            setIn(1'b1, fmtLt[i], fmtAlu[i], 32'h80FF_7F01, 1'b1, 5'(i + 1));
            InValid = 1'b1;
            expQ.push_back('{data: fmtExp[i], rw: 5'(i + 1)});
            tick();
            chk("fmt_busw", BusW, fmtExp[i]);
        end
        InValid = 1'b0;
        tick();

        // Register 0 is never written but the entry is still valid
        setIn(1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd0);
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk("r0_regwr", {31'h0, RegWr}, 32'h0);
        chk("r0_wbvalid", {31'h0, WbValid}, 32'h1);
        chk("r0_busw", BusW, 32'hDEAD_BEEF);
        tick();

        // Skid: A, B, C offered under stall; C must wait for InReady
        WbStall = 1'b1;
        setIn(1'b0, 3'b000, 32'hAAAA_0001, 32'h0, 1'b1, 5'd10);
        InValid = 1'b1;
        expQ.push_back('{data: 32'hAAAA_0001, rw: 5'd10});
        tick();
        setIn(1'b0, 3'b000, 32'hBBBB_0002, 32'h0, 1'b1, 5'd11);
        expQ.push_back('{data: 32'hBBBB_0002, rw: 5'd11});
        tick();
        chk("skid_inready_full", {31'h0, InReady}, 32'h0);
        setIn(1'b0, 3'b000, 32'hCCCC_0003, 32'h0, 1'b1, 5'd12);
        expQ.push_back('{data: 32'hCCCC_0003, rw: 5'd12});
        tick();
        chk("skid_head_busw", BusW, 32'hAAAA_0001);
        chk("skid_regwr_stalled", {31'h0, RegWr}, 32'h0);
        chk("skid_inready_held", {31'h0, InReady}, 32'h0);
        WbStall = 1'b0;
        tick();
        chk("skid_b_busw", BusW, 32'hBBBB_0002);
        chk("skid_inready_back", {31'h0, InReady}, 32'h1);
        tick();
        InValid = 1'b0;
        chk("skid_c_busw", BusW, 32'hCCCC_0003);
        tick();
        chk("skid_drained", {31'h0, WbValid}, 32'h0);

        // Flush with both entries full and an incoming entry
        WbStall = 1'b1;
        setIn(1'b0, 3'b000, 32'h0D0D_0D0D, 32'h0, 1'b1, 5'd13);
        InValid = 1'b1;
        tick();
        setIn(1'b0, 3'b000, 32'h0E0E_0E0E, 32'h0, 1'b1, 5'd14);
        tick();
        setIn(1'b0, 3'b000, 32'h0F0F_0F0F, 32'h0, 1'b1, 5'd15);
        Flush = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0; WbStall = 1'b0;
        chk("flush_wbvalid", {31'h0, WbValid}, 32'h0);
        chk("flush_regwr", {31'h0, RegWr}, 32'h0);
        chk("flush_inready", {31'h0, InReady}, 32'h1);
        repeat (3) tick();

        // Asynchronous reset while an entry is being written
        setIn(1'b0, 3'b000, 32'hCAFE_F00D, 32'h0, 1'b1, 5'd5);
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        chk("arst_pre_regwr", {31'h0, RegWr}, 32'h1);
        #1 Rst_n = 1'b0;
        #1;
        chk("arst_regwr", {31'h0, RegWr}, 32'h0);
        chk("arst_busw", BusW, 32'h0);
        chk("arst_rw", {27'h0, RW}, 32'h0);
        chk("arst_inready", {31'h0, InReady}, 32'h1);
        Rst_n = 1'b1;
        repeat (3) tick();

        chk("queue_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
